// File: rtl/mkmif_pkg.sv
// Shared constants for the MKM serial SRAM responder: opcodes, status modes, FSM states.
package mkmif_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_CMD     = 4'd1;
  localparam state_t ST_ADDR_HI = 4'd2;
  localparam state_t ST_ADDR_LO = 4'd3;
  localparam state_t ST_RD_DATA = 4'd4;
  localparam state_t ST_WR_DATA = 4'd5;
  localparam state_t ST_STAT_RD = 4'd6;
  localparam state_t ST_STAT_WR = 4'd7;
  localparam state_t ST_IGNORE  = 4'd8;

  // Reserved mode 2'b11 falls out as single-byte here.
  function automatic logic multi_byte(input logic [1:0] m);
    return (m == MODE_PAGE) || (m == MODE_SEQ);
  endfunction

endpackage

// File: rtl/mkmif_spi_sync.sv
// Two-flop synchronizers for the SPI pins plus sclk/cs_n edge pulses in the clk domain.
module mkmif_spi_sync (
  input  logic clk,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_di,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic di_sync
);

  // Deliberately not reset: a reset while cs_n is held low must not fabricate a cs_n edge.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] di_q;

  always_ff @(posedge clk) begin
    sclk_q <= {sclk_q[1:0], spi_sclk};
    cs_q   <= {cs_q[1:0], spi_cs_n};
    di_q   <= {di_q[0], spi_di};
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign di_sync   = di_q[1];

endmodule

// File: rtl/mkmif_sram_model.sv
// 23K640-style serial SRAM responder (SPI mode 0) oversampled on clk.
// Optional MKMIF_SRAM_ZEROIZE_EN adds a zeroize input that clears the whole array.
module mkmif_sram_model
  import mkmif_pkg::*;
#(
  parameter int ADDR_BITS = 13,
  parameter int PAGE_BITS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_di,
`ifdef MKMIF_SRAM_ZEROIZE_EN
  input  logic       zeroize,
`endif
  output logic       spi_do,
  output logic [1:0] mode,
  output logic       busy
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, di_sync;

  state_t state_q, state_d;
  logic [2:0]           bit_cnt;
  logic [6:0]           shift_in;
  logic [7:0]           byte_in;
  logic                 byte_done;
  logic                 op_wr;
  logic [ADDR_BITS-1:0] addr_q;
  logic [1:0]           mode_q;
  logic                 hold_dis;
  logic [7:0]           stat_byte;
  logic [7:0]           rd_byte;
  logic [7:0]           mem [DEPTH];
  logic                 wr_stb;
  logic                 addr_adv;
  logic                 clr_busy;

  mkmif_spi_sync u_sync (
    .clk       (clk),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_di    (spi_di),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .di_sync   (di_sync)
  );

  assign byte_in   = {shift_in, di_sync};
  assign byte_done = sclk_rise & (bit_cnt == 3'd7);
  assign stat_byte = {mode_q, 5'b0, hold_dis};
  assign mode      = mode_q;

  // Page mode keeps the page bits and wraps only the in-page offset.
  function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a,
                                                     input logic [1:0] m);
    logic [ADDR_BITS-1:0] n;
    n = a + 1'b1;
    if (m == MODE_PAGE) n[ADDR_BITS-1:PAGE_BITS] = a[ADDR_BITS-1:PAGE_BITS];
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_busy || cs_rise) begin
      state_d = ST_IDLE;
    end else if (cs_fall) begin
      state_d = ST_CMD;
    end else if (byte_done) begin
      case (state_q)
        ST_CMD: begin
          case (byte_in)
            OP_READ, OP_WRITE: state_d = ST_ADDR_HI;
            OP_RDSR:           state_d = ST_STAT_RD;
            OP_WRSR:           state_d = ST_STAT_WR;
            default:           state_d = ST_IGNORE;
          endcase
        end
        ST_ADDR_HI: state_d = ST_ADDR_LO;
        ST_ADDR_LO: state_d = op_wr ? ST_WR_DATA : ST_RD_DATA;
        ST_RD_DATA, ST_WR_DATA: if (!multi_byte(mode_q)) state_d = ST_IGNORE;
        ST_STAT_WR: state_d = ST_IGNORE;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE) | clr_busy;
    wr_stb   = (state_q == ST_WR_DATA) & byte_done & ~cs_rise;
    addr_adv = ((state_q == ST_WR_DATA) | (state_q == ST_RD_DATA)) & byte_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      shift_in <= '0;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      mode_q   <= MODE_BYTE;
      hold_dis <= 1'b0;
      spi_do   <= 1'b0;
    end else begin
      if (cs_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= byte_in[6:0];
      end
      if (state_q == ST_CMD && byte_done) op_wr <= (byte_in == OP_WRITE);
      // Shifting all 16 address bits through an ADDR_BITS register keeps only the low bits.
      if ((state_q == ST_ADDR_HI || state_q == ST_ADDR_LO) && sclk_rise)
        addr_q <= {addr_q[ADDR_BITS-2:0], di_sync};
      else if (addr_adv)
        addr_q <= next_addr(addr_q, mode_q);
      if (state_q == ST_STAT_WR && byte_done) begin
        mode_q   <= byte_in[7:6];
        hold_dis <= byte_in[0];
      end
      // bit_cnt counts rising edges within the byte, so the next bit out is 7-bit_cnt.
      if (clr_busy || cs_rise) begin
        spi_do <= 1'b0;
      end else if (state_q == ST_RD_DATA) begin
        if (sclk_fall) spi_do <= rd_byte[~bit_cnt];
      end else if (state_q == ST_STAT_RD) begin
        if (sclk_fall) spi_do <= stat_byte[~bit_cnt];
      end else begin
        spi_do <= 1'b0;
      end
    end
  end

`ifdef MKMIF_SRAM_ZEROIZE_EN
  logic                 clr_active;
  logic [ADDR_BITS-1:0] clr_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_active <= 1'b0;
      clr_addr   <= '0;
    end else if (clr_active) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == '1) clr_active <= 1'b0;
    end else if (zeroize) begin
      clr_active <= 1'b1;
      clr_addr   <= '0;
    end
  end

  assign clr_busy = clr_active;

  always_ff @(posedge clk) begin
    if (clr_active)  mem[clr_addr] <= 8'h00;
    else if (wr_stb) mem[addr_q]   <= byte_in;
    rd_byte <= mem[addr_q];
  end
`else
  assign clr_busy = 1'b0;

  always_ff @(posedge clk) begin
    if (wr_stb) mem[addr_q] <= byte_in;
    rd_byte <= mem[addr_q];
  end
`endif

endmodule

// File: tb/tb_mkmif_sram_model.sv
// Bench for mkmif_sram_model: bit-banged SPI master against a byte-level reference model.
module tb_mkmif_sram_model;

  localparam int DEPTH = 8192;
  localparam int HALF  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_di = 1'b0;
  logic       spi_do;
  logic [1:0] mode;
  logic       busy;
`ifdef MKMIF_SRAM_ZEROIZE_EN
  logic       zeroize = 1'b0;
`endif

  always #5 clk = ~clk;

  mkmif_sram_model dut (
    .clk      (clk),
    .reset    (reset),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_di   (spi_di),
`ifdef MKMIF_SRAM_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .spi_do   (spi_do),
    .mode     (mode),
    .busy     (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned ref_mem   [DEPTH];
  bit           ref_known [DEPTH];
  logic [1:0]   ref_mode = 2'b00;
  bit           ref_hold = 1'b0;
  byte unsigned tx [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    spi_di = b;
    clk_wait(HALF);
    r = spi_do;
    spi_sclk = 1'b1;
    clk_wait(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic frame(input byte unsigned txq[$], input int tail_bits, output byte unsigned rx[$]);
    logic r;
    byte unsigned acc;
    byte unsigned cur;
    rx = {};
    acc = 8'h00;
    spi_cs_n = 1'b0;
    clk_wait(HALF);
    chk("busy_in_frame", busy, 1);
    foreach (txq[i]) begin
      cur = txq[i];
      for (int b = 7; b >= 0; b--) begin
        xfer_bit(cur[b], r);
        acc = {acc[6:0], r};
      end
      rx.push_back(acc);
    end
    for (int b = 0; b < tail_bits; b++) xfer_bit(1'b1, r);
    clk_wait(HALF);
    spi_cs_n = 1'b1;
    clk_wait(3 * HALF);
  endtask

  function automatic int ref_next(input int a, input logic [1:0] m);
    if (m == 2'b01) return (a + 1) % DEPTH;
    return (a / 32) * 32 + (a + 1) % 32;
  endfunction

  task automatic run_frame(input string tag, input byte unsigned txq[$], input int tail_bits);
    byte unsigned rx [$];
    int  a;
    int  n;
    bit  multi;
    byte unsigned op;
    frame(txq, tail_bits, rx);
    n     = txq.size();
    op    = txq[0];
    multi = (ref_mode == 2'b01) || (ref_mode == 2'b10);
    chk({tag, ".cmd_do"}, rx[0], 0);
    if (op == 8'h05) begin
      for (int i = 1; i < n; i++) chk({tag, ".rdsr"}, rx[i], {ref_mode, 5'b0, ref_hold});
    end else if (op == 8'h01) begin
      if (n > 1) begin
        ref_mode = txq[1][7:6];
        ref_hold = txq[1][0];
      end
    end else if (op == 8'h02 || op == 8'h03) begin
      if (n >= 3) begin
        a = (int'(txq[1]) * 256 + int'(txq[2])) % DEPTH;
        for (int i = 3; i < n; i++) begin
          if (i == 3 || multi) begin
            if (op == 8'h02) begin
              ref_mem[a]   = txq[i];
              ref_known[a] = 1'b1;
            end else if (ref_known[a]) begin
              chk({tag, ".rd"}, rx[i], ref_mem[a]);
            end
            if (multi) a = ref_next(a, ref_mode);
          end else if (op == 8'h03) begin
            chk({tag, ".rd_past"}, rx[i], 0);
          end
        end
      end
    end else begin
      for (int i = 1; i < n; i++) chk({tag, ".ignore"}, rx[i], 0);
    end
    chk({tag, ".mode"}, mode, ref_mode);
    chk({tag, ".idle_busy"}, busy, 0);
  endtask

  task automatic mem_frame(input string tag, input byte unsigned op, input int a16,
                           input byte unsigned data[$], input int tail_bits);
    byte unsigned q [$];
    q = {};
    q.push_back(op);
    q.push_back(8'((a16 >> 8) & 255));
    q.push_back(8'(a16 & 255));
    foreach (data[i]) q.push_back(data[i]);
    run_frame(tag, q, tail_bits);
  endtask

  initial begin
    byte unsigned d [$];
    byte unsigned v;
    logic r;
    int a16;
    int sel;
    int len;

    clk_wait(6);
    chk("reset.busy", busy, 0);
    chk("reset.mode", mode, 2'b00);
    chk("reset.spi_do", spi_do, 0);
    reset = 1'b0;
    clk_wait(6);

    tx = {8'h05, 8'h00};
    run_frame("rdsr0", tx, 0);
    tx = {8'h01, 8'h41};
    run_frame("wrsr41", tx, 0);
    chk("plan.mode_seq", mode, 2'b01);
    tx = {8'h05, 8'h00, 8'h00};
    run_frame("rdsr41", tx, 0);

    d = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    mem_frame("seq_wr", 8'h02, 16'h0010, d, 0);
    d = {8'h00, 8'h00, 8'h00, 8'h00};
    mem_frame("seq_rd", 8'h03, 16'h0010, d, 0);

    d = {8'h55, 8'h66};
    mem_frame("prefill", 8'h02, 16'h0020, d, 0);
    tx = {8'h01, 8'h00};
    run_frame("wrsr_byte", tx, 0);
    d = {8'h11, 8'h22};
    mem_frame("byte_wr", 8'h02, 16'h0020, d, 0);
    d = {8'h00, 8'h00};
    mem_frame("byte_rd", 8'h03, 16'h0020, d, 0);
    tx = {8'h01, 8'h40};
    run_frame("wrsr_seq", tx, 0);
    mem_frame("byte_chk", 8'h03, 16'h0020, d, 0);

    tx = {8'h01, 8'h81};
    run_frame("wrsr_page", tx, 0);
    d = {8'hAA, 8'hBB};
    mem_frame("page_wr", 8'h02, 16'h003F, d, 0);
    tx = {8'h01, 8'h40};
    run_frame("wrsr_seq2", tx, 0);
    d = {8'h00};
    mem_frame("page_chk3f", 8'h03, 16'h003F, d, 0);
    mem_frame("page_chk20", 8'h03, 16'h0020, d, 0);

    d = {8'h77, 8'h88};
    mem_frame("wrap_wr", 8'h02, 16'h1FFF, d, 0);
    d = {8'h00, 8'h00};
    mem_frame("wrap_rd", 8'h03, 16'h1FFF, d, 0);

    d = {};
    mem_frame("partial_wr", 8'h02, 16'h0010, d, 4);
    d = {8'h00};
    mem_frame("partial_chk", 8'h03, 16'h0010, d, 0);
    mem_frame("trunc_rd", 8'h03, 16'hE010, d, 0);

    // Reset in the middle of a WRSR frame; the rest of that frame must be ignored.
    spi_cs_n = 1'b0;
    clk_wait(HALF);
    v = 8'h01;
    for (int b = 7; b >= 0; b--) xfer_bit(v[b], r);
    v = 8'hC1;
    for (int b = 7; b >= 4; b--) xfer_bit(v[b], r);
    reset = 1'b1;
    clk_wait(3);
    reset = 1'b0;
    clk_wait(2);
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.mode", mode, 2'b00);
    for (int b = 3; b >= 0; b--) xfer_bit(v[b], r);
    for (int b = 7; b >= 0; b--) xfer_bit(v[b], r);
    clk_wait(HALF);
    spi_cs_n = 1'b1;
    clk_wait(3 * HALF);
    ref_mode = 2'b00;
    ref_hold = 1'b0;
    chk("rst_mid.mode_after", mode, 2'b00);
    tx = {8'h05, 8'h00};
    run_frame("rst_mid.rdsr", tx, 0);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 10);
      a16 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 63))
                                         : DEPTH - 32 + int'($urandom_range(0, 31));
      a16 = a16 + DEPTH * int'($urandom_range(0, 7));
      len = $urandom_range(1, 4);
      d = {};
      if (sel <= 3) begin
        for (int i = 0; i < len; i++) d.push_back(8'($urandom_range(0, 255)));
        mem_frame("rnd_wr", 8'h02, a16, d, ($urandom_range(0, 7) == 0) ? 3 : 0);
      end else if (sel <= 7) begin
        for (int i = 0; i < len; i++) d.push_back(8'h00);
        mem_frame("rnd_rd", 8'h03, a16, d, 0);
      end else if (sel == 8) begin
        tx = {8'h05, 8'h00, 8'h00};
        run_frame("rnd_rdsr", tx, 0);
      end else if (sel == 9) begin
        tx = {8'h01, 8'(($urandom_range(0, 3) << 6) | $urandom_range(0, 1))};
        run_frame("rnd_wrsr", tx, 0);
      end else begin
        tx = {8'hA5, 8'h00, 8'h00};
        run_frame("rnd_badop", tx, 0);
      end
    end

`ifdef MKMIF_SRAM_ZEROIZE_EN
    begin
      int cnt;
      zeroize = 1'b1;
      clk_wait(1);
      zeroize = 1'b0;
      cnt = 0;
      while (busy && cnt < 9000) begin
        cnt++;
        clk_wait(1);
      end
      chk("zeroize.busy_cycles", cnt, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        ref_mem[i]   = 8'h00;
        ref_known[i] = 1'b1;
      end
      tx = {8'h01, 8'h40};
      run_frame("zeroize.wrsr", tx, 0);
      d = {8'h00};
      mem_frame("zeroize.rd", 8'h03, 16'h0010, d, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mkmif_sram_model.md
Name: mkmif_sram_model

Overview:
- Synthesizable SPI responder emulating the 23K640-style serial SRAM addressed by the MKM interface; the other end of the MKM SPI link.
- Used in FPGA self-test builds and simulation benches in place of the external chip.
- Oversamples the SPI pins on the system clock, decodes READ/WRITE/RDSR/WRSR, holds a byte-wide internal array and drives spi_do.

Parameters:
- ADDR_BITS, 13, byte-address width; array depth is 2**ADDR_BITS bytes. The 16-bit SPI address is truncated to the low ADDR_BITS bits.
- PAGE_BITS, 5, page size is 2**PAGE_BITS bytes, used in page mode.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock from the master.
- spi_cs_n  in  1  chip select, active low.
- spi_di  in  1  serial data into the memory (master MOSI).
- spi_do  out  1  serial data out of the memory (master MISO).
- mode  out  2  current status-register mode field, for debug.
- busy  out  1  high while a transaction is active (cs_n low and synchronized).

Behaviour:
- Reset: spi_do=0, mode=2'b00 (byte mode), busy=0, status hold bit=0, FSM=IDLE. Array contents are not reset.
- Input synchronization: spi_sclk, spi_cs_n and spi_di each pass through 2 flops. Rising and falling edges of sclk are detected from the synchronized value.
- Clock-ratio requirement: spi_sclk high and low phases must each be at least 3 clk cycles.
- SPI timing: mode 0. Sample spi_di on the rising sclk edge, MSB first. Update spi_do on the falling edge. The first output bit appears after the falling edge that follows the last command/address bit.
- Transaction boundaries:
  - Synchronized cs_n falling → CMD, bit counter=0.
  - Synchronized cs_n rising in any state → IDLE, spi_do=0. A partially shifted write byte is discarded.
- FSM states and transitions:
  - IDLE: wait for cs_n falling.
  - CMD: shift 8 bits, then decode.
    - 0x03 → ADDR_HI with op=read.
    - 0x02 → ADDR_HI with op=write.
    - 0x05 → STAT_RD.
    - 0x01 → STAT_WR.
    - Any other opcode → IGNORE.
  - ADDR_HI, then ADDR_LO: shift 16 address bits total, then go to RD_DATA or WR_DATA.
  - RD_DATA: load mem[addr] into the output shifter; shift out 8 bits, then advance the address and reload.
  - WR_DATA: after every 8th rising edge, write the byte to mem[addr] (one-cycle write strobe), then advance the address.
  - STAT_RD: repeatedly shift out {mode, 5'b0, hold_dis}.
  - STAT_WR: on the 8th bit, mode←bits[7:6], hold_dis←bit[0], then → IGNORE.
  - IGNORE: spi_do=0; remain until cs_n rises.
- Address advance, by mode:
  - 2'b00 byte: after 1 byte → IGNORE.
  - 2'b10 page: the low PAGE_BITS bits increment and wrap; the upper bits are held.
  - 2'b01 sequential: full ADDR_BITS increment, wrapping from 2**ADDR_BITS-1 to 0.
  - 2'b11 reserved: treated as byte mode.
- Read-after-write: a byte written in one transaction is readable in the next (write completes ≥2 clk before the cs_n rising edge is seen).
- Reset mid-transaction: FSM→IDLE and status back to defaults. The remainder of the frame is ignored until the next cs_n falling edge.

Optional Feature:
- Macro: MKMIF_SRAM_ZEROIZE_EN.
- With the macro defined:
  - Adds input port zeroize (1 bit).
  - A pulse starts a counter that writes 0x00 to every address, one per clk, taking 2**ADDR_BITS cycles.
  - busy is held high while clearing, and SPI frames are ignored (spi_do=0).
  - Reset aborts the clear.
  - zeroize pulses during a clear are ignored.
- Without the macro: no port and no clear logic.

Decomposition:
- mkmif_pkg holds:
  - opcode constants READ=8'h03, WRITE=8'h02, RDSR=8'h05, WRSR=8'h01;
  - mode encodings BYTE/PAGE/SEQ;
  - FSM state localparams.
- Sub-module mkmif_spi_sync: the 2-flop synchronizers plus sclk rise/fall and cs_n fall/rise pulse generation.

Test Plan:
- Reset, then RDSR frame (0x05) → shifted-out byte 0x00, mode=2'b00.
- WRSR 0x41, then RDSR → reads 0x41, mode=2'b01.
- Sequential mode: WRITE 0x02 addr 0x0010 data DE AD BE EF, then READ 0x03 addr 0x0010 for 4 bytes → DE AD BE EF.
- Byte mode: WRITE addr 0x0020 bytes 11 22 → only mem[0x20]=0x11; mem[0x21] unchanged. A subsequent READ of 2 bytes returns 0x11 then 0x00.
- Page mode (WRSR 0x81): WRITE addr 0x003F bytes AA BB → mem[0x3F]=AA, mem[0x20]=BB. Sequential mode: READ addr 0x1FFF for 2 bytes wraps to mem[0x0000].
- cs_n raised after 4 data bits of a WRITE → the target byte is unchanged. With MKMIF_SRAM_ZEROIZE_EN, a zeroize pulse → busy high for 8192 cycles, then READ addr 0x0010 returns 0x00.
